adc_scan_top: RTL

ADC_SCAN_TOP -- requirements
Module: adc_scan_top

---
 rtl/adc_scan_pkg.sv | 30 +++
 rtl/adc_scan_acc.sv | 51 +++++
 rtl/adc_scan_top.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/adc_scan_pkg.sv
// Shared types and defaults for the multiplexed ADC scan controller.
package adc_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_INTEGRATE,
    ST_DUMP
  } state_e;

  localparam int DEF_N_CH  = 4;
  localparam int DEF_RES_W = 16;
  localparam int DEF_OSR_W = 16;
  localparam int DEF_SET_W = 8;

  // Returns {found, ch}: lowest enabled channel above cur (or at cur when incl).
  function automatic logic [4:0] next_ch(input logic [15:0] mask,
                                         input logic [3:0]  cur,
                                         input logic        incl);
    logic [4:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      if (mask[i] && ((i > int'(cur)) || (incl && (i == int'(cur))))) begin
        r = {1'b1, 4'(i)};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_scan_acc.sv
// Integration window: counts cycles and ones while enabled; done on the last window cycle.
// Output is the ones count saturated to RES_W bits; no flow control.
module adc_scan_acc #(
  parameter int OSR_W = 16,
  parameter int RES_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             bit_i,
  input  logic [OSR_W-1:0] osr_i,
  output logic             done_o,
  output logic [RES_W-1:0] result_o
);

  localparam int W = (OSR_W > RES_W) ? OSR_W : RES_W;

  logic [OSR_W-1:0] cnt_q, cnt_d;
  logic [OSR_W-1:0] acc_q, acc_d;
  logic [OSR_W-1:0] osr_eff;
  logic [W-1:0]     acc_ext;

  always_comb begin
    osr_eff = (osr_i == '0) ? OSR_W'(1) : osr_i;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    if (clr_i) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + OSR_W'(1);
      if (bit_i) acc_d = acc_q + OSR_W'(1);
    end
  end

  assign done_o   = en_i && (cnt_q == (osr_eff - OSR_W'(1)));
  assign acc_ext  = W'(acc_q);
  assign result_o = (acc_ext > W'({RES_W{1'b1}})) ? {RES_W{1'b1}} : acc_ext[RES_W-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/adc_scan_top.sv
// Round-robin scan over enabled mux channels: settle, integrate osr samples, dump one result each.
// Result register is single-entry; an unaccepted result is overwritten and flagged as overrun.
module adc_scan_top
  import adc_scan_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int RES_W = DEF_RES_W,
  parameter int OSR_W = DEF_OSR_W,
  parameter int SET_W = DEF_SET_W,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             comp_in,
  input  logic             start_conversion_in,
  input  logic             abort_in,
  input  logic [N_CH-1:0]  ch_mask_in,
  input  logic [OSR_W-1:0] osr_in,
  input  logic [SET_W-1:0] settle_in,
  input  logic             continuous_in,
  output logic [CH_W-1:0]  ch_sel_out,
  output logic [RES_W-1:0] result_out,
  output logic [CH_W-1:0]  result_ch_out,
  output logic             result_valid_out,
  input  logic             result_ready_in,
  output logic             busy_out,
  output logic             conversion_finished_out,
  output logic             overrun_out
);

  state_e           state_q, state_d;
  logic [N_CH-1:0]  mask_q, mask_d;
  logic [OSR_W-1:0] osr_q, osr_d;
  logic [SET_W-1:0] settle_q, settle_d, set_cnt_q, set_cnt_d;
  logic             cont_q, cont_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [RES_W-1:0] result_q, result_d, acc_res;
  logic [CH_W-1:0]  res_ch_q, res_ch_d;
  logic             valid_q, valid_d, fin_q, fin_d, ovr_q, ovr_d;
  logic             acc_clr, acc_en, acc_done, dump, start_ok, settle_done;
  logic [4:0]       nxt, lowest, lowest_in;

  assign nxt         = next_ch(16'(mask_q), 4'(ch_q), 1'b0);
  assign lowest      = next_ch(16'(mask_q), 4'd0, 1'b1);
  assign lowest_in   = next_ch(16'(ch_mask_in), 4'd0, 1'b1);
  assign start_ok    = (state_q == ST_IDLE) && start_conversion_in && (|ch_mask_in) && !abort_in;
  assign settle_done = ({1'b0, set_cnt_q} + (SET_W+1)'(1)) >= {1'b0, settle_q};

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    mask_d    = mask_q;
    osr_d     = osr_q;
    settle_d  = settle_q;
    cont_d    = cont_q;
    set_cnt_d = '0;
    case (state_q)
      ST_IDLE: if (start_ok) begin
        state_d  = ST_SETTLE;
        ch_d     = CH_W'(lowest_in[3:0]);
        mask_d   = ch_mask_in;
        osr_d    = osr_in;
        settle_d = settle_in;
        cont_d   = continuous_in;
      end
      ST_SETTLE: begin
        set_cnt_d = set_cnt_q + SET_W'(1);
        if (settle_done) state_d = ST_INTEGRATE;
      end
      ST_INTEGRATE: if (acc_done) state_d = ST_DUMP;
      ST_DUMP: begin
        if (nxt[4]) begin
          state_d = ST_SETTLE;
          ch_d    = CH_W'(nxt[3:0]);
        end else if (cont_q) begin
          state_d = ST_SETTLE;
          ch_d    = CH_W'(lowest[3:0]);
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort_in) state_d = ST_IDLE;
  end

  always_comb begin
    busy_out = (state_q != ST_IDLE);
    acc_en   = (state_q == ST_INTEGRATE);
    acc_clr  = (state_q != ST_INTEGRATE);
    dump     = (state_q == ST_DUMP);
  end

  adc_scan_acc #(.OSR_W(OSR_W), .RES_W(RES_W)) u_acc (
    .clk_i    (clk),
    .rst_i    (rst),
    .clr_i    (acc_clr),
    .en_i     (acc_en),
    .bit_i    (comp_in),
    .osr_i    (osr_q),
    .done_o   (acc_done),
    .result_o (acc_res)
  );

  // Accept and a fresh result in the same cycle keeps valid high without overrun.
  always_comb begin
    result_d = result_q;
    res_ch_d = res_ch_q;
    valid_d  = valid_q && !result_ready_in;
    ovr_d    = ovr_q;
    fin_d    = 1'b0;
    if (dump && !abort_in) begin
      result_d = acc_res;
      res_ch_d = ch_q;
      valid_d  = 1'b1;
      fin_d    = !nxt[4];
      if (valid_q && !result_ready_in) ovr_d = 1'b1;
    end
    if (start_ok) ovr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q    <= '0;
      osr_q     <= '0;
      settle_q  <= '0;
      cont_q    <= 1'b0;
      set_cnt_q <= '0;
      ch_q      <= '0;
      result_q  <= '0;
      res_ch_q  <= '0;
      valid_q   <= 1'b0;
      fin_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      mask_q    <= mask_d;
      osr_q     <= osr_d;
      settle_q  <= settle_d;
      cont_q    <= cont_d;
      set_cnt_q <= set_cnt_d;
      ch_q      <= ch_d;
      result_q  <= result_d;
      res_ch_q  <= res_ch_d;
      valid_q   <= valid_d;
      fin_q     <= fin_d;
      ovr_q     <= ovr_d;
    end
  end

  assign ch_sel_out              = ch_q;
  assign result_out              = result_q;
  assign result_ch_out           = res_ch_q;
  assign result_valid_out        = valid_q;
  assign conversion_finished_out = fin_q;
  assign overrun_out             = ovr_q;

endmodule
